mdu_ctrl: RTL and testbench

Sequencing controller for the multi-cycle multiply/divide unit in the pipelined CPU. It accepts MDU-class instructions from the E stage and owns the architectural HI/LO registers. It latches the result from the external combinational arithmetic array, models the multiply/divide latency with a countdown, and generates the D-stage stall that keeps dependent MDU instructions from issuing while an operation is in flight.

---
 rtl/mdu_ctrl.sv | 132 +++++++++++++
 tb/tb_mdu_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencing controller for the multi-cycle multiply/divide unit.
// Owns architectural HI/LO, latches the external array result into a shadow
// pair at issue, counts down the modelled latency, then commits HI/LO at once.
// Optional feature macro: MDU_DIV0_FAST_EN (divide by zero retires in one
// cycle with no HI/LO side effect).
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_srcA,
    input  logic [31:0] e_srcB,
    input  logic [31:0] calc_hi,
    input  logic [31:0] calc_lo,
    input  logic        d_is_mdu,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        start,
    output logic        stall
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] shadow_hi;
    logic [31:0] shadow_lo;
    logic        is_mul;
    logic        is_div;
    logic        div0_skip;

    assign is_mul = (e_op == OP_MULT) || (e_op == OP_MULTU);
    assign is_div = (e_op == OP_DIV)  || (e_op == OP_DIVU);

`ifdef MDU_DIV0_FAST_EN
    assign div0_skip = (e_srcB == '0);
`else
    // Divisor is only inspected by the fast divide-by-zero path.
    logic unused_srcb;
    assign unused_srcb = ^e_srcB;
    assign div0_skip   = 1'b0;
`endif

    // An arithmetic op is accepted only while idle; a fast div0 still counts as accepted.
    assign start = (state == IDLE) && (is_mul || is_div);
    assign stall = d_is_mdu && (busy || start);

    // Move-from read port.
    always_comb begin
        rd_data = '0;
        case (e_op)
            OP_MFHI: rd_data = hi;
            OP_MFLO: rd_data = lo;
            default: rd_data = '0;
        endcase
    end

    // Controller FSM: issue, latency countdown, atomic HI/LO commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        shadow_hi <= calc_hi;
                        shadow_lo <= calc_lo;
                        cnt       <= MULT_CNT;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else if (is_div && !div0_skip) begin
                        shadow_hi <= calc_hi;
                        shadow_lo <= calc_lo;
                        cnt       <= DIV_CNT;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else if (e_op == OP_MTHI) begin
                        hi <= e_srcA;
                    end else if (e_op == OP_MTLO) begin
                        lo <= e_srcA;
                    end
                end
                RUN: begin
                    // Any op arriving here slipped past the stall and is dropped.
                    if (cnt == 4'd1) begin
                        hi    <= shadow_hi;
                        lo    <= shadow_lo;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table, hand-written multi-cycle corner
// sequences, then random traffic checked against a time-based reference model.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  e_op;
    logic [31:0] e_srcA, e_srcB, calc_hi, calc_lo;
    logic        d_is_mdu;
    logic [31:0] hi, lo, rd_data;
    logic        busy, start, stall;

    int n_vec  = 0;
    int n_fail = 0;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .e_op(e_op), .e_srcA(e_srcA), .e_srcB(e_srcB),
        .calc_hi(calc_hi), .calc_lo(calc_lo), .d_is_mdu(d_is_mdu),
        .hi(hi), .lo(lo), .rd_data(rd_data), .busy(busy), .start(start), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an accepted op finishes at an absolute edge number.
    int          cyc;
    int          done_at;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    function automatic bit fast_div0();
`ifdef MDU_DIV0_FAST_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        cyc = 0; done_at = 0;
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
    endtask

    function automatic bit m_busy();
        return cyc < done_at;
    endfunction

    task automatic model_edge();
        bit idle;
        if (!reset) begin
            model_clear();
            return;
        end
        idle = !m_busy();
        cyc++;
        if (!idle) begin
            if (cyc == done_at) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else begin
            case (e_op)
                4'd1, 4'd2: begin p_hi = calc_hi; p_lo = calc_lo; done_at = cyc + MULT_N; end
                4'd3, 4'd4: if (!(fast_div0() && e_srcB == 0)) begin
                    p_hi = calc_hi; p_lo = calc_lo; done_at = cyc + DIV_N;
                end
                4'd7: m_hi = e_srcA;
                4'd8: m_lo = e_srcA;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ch, input logic [31:0] cl,
                         input logic d);
        reset = rst; e_op = op; e_srcA = a; e_srcB = b; calc_hi = ch; calc_lo = cl; d_is_mdu = d;
        if (!rst) model_clear();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model();
        bit exp_start;
        logic [31:0] exp_rd;
        exp_start = !m_busy() && (e_op >= 4'd1) && (e_op <= 4'd4);
        exp_rd = (e_op == 4'd5) ? m_hi : (e_op == 4'd6) ? m_lo : 32'd0;
        chk("busy",    {31'd0, busy},  {31'd0, m_busy()});
        chk("hi",      hi,             m_hi);
        chk("lo",      lo,             m_lo);
        chk("start",   {31'd0, start}, {31'd0, exp_start});
        chk("stall",   {31'd0, stall}, {31'd0, d_is_mdu && (m_busy() || exp_start)});
        chk("rd_data", rd_data,        exp_rd);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, chi, clo;
        logic        d;
        logic        busy;
        logic [31:0] hi, lo;
        logic        start, stall;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] chi,
                                logic [31:0] clo, logic d, logic bz, logic [31:0] h, logic [31:0] l,
                                logic st, logic sl, logic [31:0] rd);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.chi = chi; v.clo = clo; v.d = d;
        v.busy = bz; v.hi = h; v.lo = l; v.start = st; v.stall = sl; v.rd = rd;
        return v;
    endfunction

    initial begin
        int busy_cycles;

        // Directed table: mult with RUN violation, mthi/mtlo, divu with mflo behind it.
        tbl.push_back(mk(4'd1, 0, 0, 32'h1, 32'h2, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(4'd0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'd7, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'd5, 0, 0, 0, 0, 1,          1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'd0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(4'd0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd6, 0, 0, 0, 0, 0,          0, 32'h1, 32'h2, 0, 0, 32'h2));
        tbl.push_back(mk(4'd7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h1, 32'h2, 0, 0, 0));
        tbl.push_back(mk(4'd8, 32'h12345678, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h2, 0, 0, 0));
        tbl.push_back(mk(4'd5, 0, 0, 0, 0, 0,          0, 32'hDEADBEEF, 32'h12345678, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(4'd4, 0, 32'd2, 32'd3, 32'd7, 1, 0, 32'hDEADBEEF, 32'h12345678, 1, 1, 0));
        for (int i = 0; i < DIV_N; i++)
            tbl.push_back(mk(4'd6, 0, 0, 0, 0, 1,      1, 32'hDEADBEEF, 32'h12345678, 0, 1, 32'h12345678));
        tbl.push_back(mk(4'd6, 0, 0, 0, 0, 1,          0, 32'd3, 32'd7, 0, 0, 32'd7));

        // Reset state.
        drive(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].chi, tbl[i].clo, tbl[i].d);
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", i),  {31'd0, busy},  {31'd0, tbl[i].busy});
            chk($sformatf("tbl%0d_hi", i),    hi,             tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i),    lo,             tbl[i].lo);
            chk($sformatf("tbl%0d_start", i), {31'd0, start}, {31'd0, tbl[i].start});
            chk($sformatf("tbl%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].stall});
            chk($sformatf("tbl%0d_rd", i),    rd_data,        tbl[i].rd);
            tick();
        end

        // Divide by zero with HI/LO preloaded to 5/6.
        drive(1, 4'd7, 32'd5, 0, 0, 0, 0); tick();
        drive(1, 4'd8, 32'd6, 0, 0, 0, 0); tick();
        drive(1, 4'd3, 32'd9, 32'd0, 32'hAAAA, 32'hBBBB, 0);
        @(negedge clk);
        chk("div0_start", {31'd0, start}, 32'd1);
        tick();
        drive(1, 4'd0, 0, 0, 0, 0, 0);
        busy_cycles = 0;
        for (int i = 0; i < DIV_N + 2; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            tick();
        end
`ifdef MDU_DIV0_FAST_EN
        chk("div0_busy_cycles", busy_cycles, 0);
        chk("div0_hi", hi, 32'd5);
        chk("div0_lo", lo, 32'd6);
`else
        chk("div0_busy_cycles", busy_cycles, DIV_N);
        chk("div0_hi", hi, 32'hAAAA);
        chk("div0_lo", lo, 32'hBBBB);
`endif

        // Reset pulled low during cycle 3 of a div.
        drive(1, 4'd7, 32'h11, 0, 0, 0, 0); tick();
        drive(1, 4'd8, 32'h22, 0, 0, 0, 0); tick();
        drive(1, 4'd3, 0, 32'd3, 32'h77, 32'h88, 0); tick();
        drive(1, 4'd0, 0, 0, 0, 0, 0); tick(); tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_hi", hi, 32'h11);
        #2;
        drive(0, 4'd0, 0, 0, 0, 0, 0);
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        tick();
        drive(1, 4'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DIV_N + 2; i++) begin
            @(negedge clk);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_hi", hi, 32'd0);
            chk("post_rst_lo", lo, 32'd0);
            tick();
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic rst_v;
            logic [31:0] b_v;
            rst_v = ($urandom_range(0, 63) != 0);
            b_v = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            drive(rst_v, 4'($urandom_range(0, 15)), $urandom, b_v, $urandom, $urandom,
                  1'($urandom_range(0, 1)));
            @(negedge clk);
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
